// File: rtl/uart_ctrl_pkg.sv
// Shared types and register map for the UART port arbiter.
// The FSM, its sub-blocks and any test code all import this package.
package uart_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_SEL,
    ST_RX_CAPT,
    ST_RX_CLR,
    ST_TX_LOAD,
    ST_TX_START,
    ST_TX_WAIT,
    ST_TX_ABORT,
    ST_SETTLE
  } state_t;

  localparam logic CTRL_REG = 1'b0;
  localparam logic DATA_REG = 1'b1;

  localparam int unsigned CTRL_SEND_BIT = 0;
  localparam int unsigned CTRL_RX_BIT   = 1;

  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/uart_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr,
// wrapping around, as a one-hot vector plus its index.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    grant_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    // Scan ptr+1 .. ptr+N_REQ so the last winner is considered last.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      if (!found && req[PW'(idx)]) begin
        grant[PW'(idx)] = 1'b1;
        grant_idx       = PW'(idx);
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_port_arbiter.sv
// Sequences the UART control/data register interface: services RX bytes first,
// then shares the transmitter between N_REQ requesters round-robin.
module uart_port_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned TX_TIMEOUT = 200000
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic [31:0]          salida_perif_i,
  output logic                 wr_o,
  output logic                 reg_sel_o,
  output logic [31:0]          entrada_perif_o,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  output logic                 busy_o,
  output logic                 tx_error_o,
  input  logic                 clear_err_i
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TX_TIMEOUT) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TX_TIMEOUT - 1);

  state_t            st, st_d;
  logic [PW-1:0]     ptr, ptr_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [N_REQ-1:0]  gnt;
  logic [PW-1:0]     gnt_idx;
  logic [7:0]        gnt_byte;

  logic              wr_d, sel_d, rx_valid_d, busy_d, err_d;
  logic [31:0]       din_d;
  logic [7:0]        rx_data_d;
  logic [N_REQ-1:0]  ready_d;

  logic              unused_bits;
  assign unused_bits = ^salida_perif_i[31:8];

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid_i),
    .ptr       (ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  always_comb begin
    gnt_byte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      gnt_byte = gnt_byte | (req_data_i[8*i +: 8] & {8{gnt[i]}});
    end
  end

  // Outputs are decoded from the next state and registered, so each output
  // register holds the value belonging to the state it is entering.
  always_comb begin
    st_d       = st;
    ptr_d      = ptr;
    cnt_d      = cnt;
    wr_d       = 1'b0;
    sel_d      = CTRL_REG;
    din_d      = '0;
    rx_data_d  = rx_data_o;
    rx_valid_d = 1'b0;
    ready_d    = '0;
    err_d      = tx_error_o & ~clear_err_i;

    unique case (st)
      ST_IDLE: begin
        if (salida_perif_i[CTRL_RX_BIT]) begin
          st_d  = ST_RX_SEL;
          sel_d = DATA_REG;
        end else if (|req_valid_i) begin
          st_d    = ST_TX_LOAD;
          ptr_d   = gnt_idx;
          wr_d    = 1'b1;
          sel_d   = DATA_REG;
          din_d   = byte_word(gnt_byte);
          ready_d = gnt;
        end
      end
      ST_RX_SEL: begin
        st_d       = ST_RX_CAPT;
        sel_d      = DATA_REG;
        rx_data_d  = salida_perif_i[7:0];
        rx_valid_d = 1'b1;
      end
      ST_RX_CAPT: begin
        st_d = ST_RX_CLR;
        wr_d = 1'b1;
      end
      ST_RX_CLR: st_d = ST_SETTLE;
      ST_TX_LOAD: begin
        st_d  = ST_TX_START;
        wr_d  = 1'b1;
        din_d = 32'h1;
        cnt_d = '0;
      end
      ST_TX_START: begin
        st_d  = ST_TX_WAIT;
        cnt_d = '0;
      end
      ST_TX_WAIT: begin
        // cnt == 0 marks the settling cycle, whose readback is ignored.
        if (cnt == '0) begin
          cnt_d = cnt + CW'(1);
        end else if (!salida_perif_i[CTRL_SEND_BIT]) begin
          st_d = ST_SETTLE;
        end else if (cnt == WAIT_LAST) begin
          st_d  = ST_TX_ABORT;
          wr_d  = 1'b1;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      // Abort gets its own one-cycle state carrying the reg0=0 write.
      ST_TX_ABORT: st_d = ST_SETTLE;
      ST_SETTLE:   st_d = ST_IDLE;
      default:     st_d = ST_IDLE;
    endcase

    busy_d = (st_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      st              <= ST_IDLE;
      ptr             <= PW'(N_REQ - 1);
      cnt             <= '0;
      wr_o            <= 1'b0;
      reg_sel_o       <= 1'b0;
      entrada_perif_o <= '0;
      rx_data_o       <= '0;
      rx_valid_o      <= 1'b0;
      req_ready_o     <= '0;
      busy_o          <= 1'b0;
      tx_error_o      <= 1'b0;
    end else begin
      st              <= st_d;
      ptr             <= ptr_d;
      cnt             <= cnt_d;
      wr_o            <= wr_d;
      reg_sel_o       <= sel_d;
      entrada_perif_o <= din_d;
      rx_data_o       <= rx_data_d;
      rx_valid_o      <= rx_valid_d;
      req_ready_o     <= ready_d;
      busy_o          <= busy_d;
      tx_error_o      <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Bench for uart_port_arbiter: a behavioural UART register model plus a
// round-robin reference predicting grant order, bytes sent and transaction length.
module tb_uart_port_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned TO = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic [31:0]      salida, entrada;
  logic             wr, reg_sel;
  logic [7:0]       rx_data;
  logic             rx_valid, busy, tx_error;
  logic             clear_err = 1'b0;

  int tests = 0;
  int fails = 0;

  uart_port_arbiter #(.N_REQ(N), .TX_TIMEOUT(TO)) dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .req_valid_i     (req_valid),
    .req_data_i      (req_data),
    .req_ready_o     (req_ready),
    .salida_perif_i  (salida),
    .wr_o            (wr),
    .reg_sel_o       (reg_sel),
    .entrada_perif_o (entrada),
    .rx_data_o       (rx_data),
    .rx_valid_o      (rx_valid),
    .busy_o          (busy),
    .tx_error_o      (tx_error),
    .clear_err_i     (clear_err)
  );

  always #5 clk = ~clk;

  // Peripheral model: bit0 self-clears tx_delay cycles after being written
  // (unless hang), bit1 is raised on request, data reg reads back rx_byte.
  typedef struct { logic sel; logic [31:0] data; } wr_t;
  wr_t         wlog[$];
  logic [7:0]  sent_q[$];
  logic [31:0] ctrl;
  logic [7:0]  rx_byte = '0;
  logic [7:0]  tx_hold = '0;
  int          p_cnt = 0;
  int          tx_delay = 5;
  bit          hang = 0;
  int          rx_req_cnt = 0;
  int          rx_done_cnt = 0;

  assign salida = reg_sel ? {24'h0, rx_byte} : ctrl;

  always @(posedge clk) begin : periph
    logic [31:0] c;
    wr_t w;
    if (!rst_n) begin
      ctrl <= '0;
      p_cnt = 0;
    end else begin
      c = ctrl;
      if (wr) begin
        w.sel = reg_sel;
        w.data = entrada;
        wlog.push_back(w);
        if (reg_sel) tx_hold = entrada[7:0];
        else begin
          c = entrada;
          if (entrada[0]) begin
            p_cnt = tx_delay;
            sent_q.push_back(tx_hold);
          end
        end
      end else if (c[0] && !hang) begin
        if (p_cnt <= 1) c[0] = 1'b0;
        else p_cnt--;
      end
      if (rx_req_cnt != rx_done_cnt) begin
        c[1] = 1'b1;
        rx_done_cnt = rx_req_cnt;
      end
      ctrl <= c;
    end
  end

  int ready_log[$];
  int rx_pulses = 0;
  int wr_run = 0;
  int wr_run_max = 0;
  int onehot_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr) wr_run++; else wr_run = 0;
      if (wr_run > wr_run_max) wr_run_max = wr_run;
      if (rx_valid) rx_pulses++;
      if ($countones(req_ready) > 1) onehot_err++;
      for (int i = 0; i < N; i++) if (req_ready[i]) ready_log.push_back(i);
    end
  end

  int last_gnt = N - 1;

  function automatic int model_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [32:0] wl(input int k);
    if (k < wlog.size()) return {wlog[k].sel, wlog[k].data};
    return 'x;
  endfunction

  function automatic logic [7:0] sent_at(input int k);
    if (k < sent_q.size()) return sent_q[k];
    return 'x;
  endfunction

  function automatic int ready_at(input int k);
    if (k < ready_log.size()) return ready_log[k];
    return -1;
  endfunction

  task automatic wait_idle(input bit drop, output int bcyc, output bit ok);
    bit seen;
    seen = 0; bcyc = 0; ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (drop) req_valid = req_valid & ~req_ready;
      if (busy) begin
        seen = 1;
        bcyc++;
      end else if (seen) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({wr, reg_sel, rx_valid, busy, tx_error, req_ready} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 0", {wr, reg_sel, rx_valid, busy, tx_error, req_ready});
    end
    tests++;
    if ({entrada, rx_data} !== 40'h0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0", {entrada, rx_data});
    end
    rst_n = 1'b1;
    last_gnt = N - 1;
    @(negedge clk);
  endtask

  task automatic test_single_tx(input logic [7:0] b, input int delay, input int idx);
    int w0, s0, r0, bc, exp_i;
    bit ok;
    w0 = wlog.size(); s0 = sent_q.size(); r0 = ready_log.size();
    tx_delay = delay;
    req_data[8*idx +: 8] = b;
    req_valid[idx] = 1'b1;
    exp_i = model_pick(req_valid, last_gnt);
    wait_idle(1, bc, ok);
    req_valid = '0;
    last_gnt = exp_i;
    tests++;
    if (!ok || bc != delay + 4) begin
      fails++;
      $display("FAIL single_len: got %0d cycles (done=%0d) expected %0d", bc, ok, delay + 4);
    end
    tests++;
    if (wl(w0) !== {1'b1, 24'h0, b} || wl(w0 + 1) !== {1'b0, 32'h1} || wlog.size() != w0 + 2) begin
      fails++;
      $display("FAIL single_writes: got %h,%h (n=%0d) expected %h,%h", wl(w0), wl(w0 + 1),
               wlog.size() - w0, {1'b1, 24'h0, b}, {1'b0, 32'h1});
    end
    tests++;
    if (sent_at(s0) !== b) begin
      fails++;
      $display("FAIL single_byte: got %h expected %h", sent_at(s0), b);
    end
    tests++;
    if (ready_at(r0) != exp_i || ready_log.size() != r0 + 1) begin
      fails++;
      $display("FAIL single_ready: got idx %0d count %0d expected idx %0d count 1",
               ready_at(r0), ready_log.size() - r0, exp_i);
    end
    tests++;
    if (tx_error !== 1'b0) begin
      fails++;
      $display("FAIL single_err: got %b expected 0", tx_error);
    end
  endtask

  task automatic test_rr_random();
    logic [N-1:0] mask;
    logic [7:0]   d [N];
    int r0, s0, bc, exp_i;
    bit ok;
    for (int it = 0; it < 8; it++) begin
      r0 = ready_log.size(); s0 = sent_q.size();
      tx_delay = $urandom_range(1, 12);
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        d[i] = 8'($urandom);
        req_data[8*i +: 8] = d[i];
      end
      exp_i = model_pick(mask, last_gnt);
      req_valid = mask;
      wait_idle(1, bc, ok);
      req_valid = '0;
      last_gnt = exp_i;
      tests++;
      if (!ok || ready_at(r0) != exp_i || ready_log.size() != r0 + 1) begin
        fails++;
        $display("FAIL rr_random_grant: it %0d mask %b got idx %0d expected %0d", it, mask, ready_at(r0), exp_i);
      end
      tests++;
      if (sent_at(s0) !== d[exp_i]) begin
        fails++;
        $display("FAIL rr_random_byte: it %0d got %h expected %h", it, sent_at(s0), d[exp_i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [N];
    int r0, s0, bc, exp_i;
    bit ok;
    r0 = ready_log.size(); s0 = sent_q.size();
    tx_delay = 3;
    d[0] = 8'h11; d[1] = 8'h22;
    req_data = {d[1], d[0]};
    req_valid = '1;
    for (int i = 0; i < 3000 && ready_log.size() < r0 + 4; i++) @(negedge clk);
    req_valid = '0;
    wait_idle(0, bc, ok);
    tests++;
    if (!ok || ready_log.size() != r0 + 4 || sent_q.size() != s0 + 4) begin
      fails++;
      $display("FAIL b2b_count: got %0d grants %0d sends expected 4", ready_log.size() - r0, sent_q.size() - s0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_i = model_pick('1, last_gnt);
      last_gnt = exp_i;
      tests++;
      if (ready_at(r0 + k) != exp_i || sent_at(s0 + k) !== d[exp_i]) begin
        fails++;
        $display("FAIL b2b_order: slot %0d got idx %0d byte %h expected idx %0d byte %h",
                 k, ready_at(r0 + k), sent_at(s0 + k), exp_i, d[exp_i]);
      end
    end
  endtask

  task automatic test_rx_priority(input logic [7:0] rxb, input logic [7:0] txb);
    int w0, s0, r0, p0, bc, bc2;
    bit ok, ok2;
    w0 = wlog.size(); s0 = sent_q.size(); r0 = ready_log.size(); p0 = rx_pulses;
    tx_delay = $urandom_range(1, 10);
    rx_byte = rxb;
    rx_req_cnt++;
    @(negedge clk);
    req_data[15:8] = txb;
    req_valid[1] = 1'b1;
    wait_idle(1, bc, ok);
    tests++;
    if (!ok || bc != 4 || ready_log.size() != r0) begin
      fails++;
      $display("FAIL rx_first: got %0d busy cycles %0d grants expected 4 cycles 0 grants", bc, ready_log.size() - r0);
    end
    tests++;
    if (rx_data !== rxb || rx_pulses != p0 + 1) begin
      fails++;
      $display("FAIL rx_data: got %h pulses %0d expected %h pulses 1", rx_data, rx_pulses - p0, rxb);
    end
    tests++;
    if (wl(w0) !== 33'h0) begin
      fails++;
      $display("FAIL rx_clear: got %h expected 0", wl(w0));
    end
    wait_idle(1, bc2, ok2);
    req_valid = '0;
    last_gnt = 1;
    tests++;
    if (!ok2 || sent_at(s0) !== txb || ready_at(r0) != 1 || bc2 != tx_delay + 4) begin
      fails++;
      $display("FAIL rx_then_tx: got byte %h idx %0d len %0d expected byte %h idx 1 len %0d",
               sent_at(s0), ready_at(r0), bc2, txb, tx_delay + 4);
    end
    tests++;
    if (rx_data !== rxb || rx_pulses != p0 + 1) begin
      fails++;
      $display("FAIL rx_hold: got %h pulses %0d expected %h pulses 1", rx_data, rx_pulses - p0, rxb);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    int w0, bc;
    bit ok;
    w0 = wlog.size();
    hang = 1;
    b = 8'($urandom);
    req_data[7:0] = b;
    req_valid[0] = 1'b1;
    wait_idle(1, bc, ok);
    req_valid = '0;
    last_gnt = 0;
    tests++;
    if (!ok || bc != TO + 4) begin
      fails++;
      $display("FAIL timeout_len: got %0d expected %0d", bc, TO + 4);
    end
    tests++;
    if (wl(w0 + 2) !== 33'h0 || wlog.size() != w0 + 3) begin
      fails++;
      $display("FAIL timeout_abort: got %h (n=%0d) expected 0 (n=3)", wl(w0 + 2), wlog.size() - w0);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (tx_error !== 1'b1) begin
      fails++;
      $display("FAIL timeout_err: got %b expected 1", tx_error);
    end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    tests++;
    if (tx_error !== 1'b0) begin
      fails++;
      $display("FAIL clear_err: got %b expected 0", tx_error);
    end
    hang = 0;
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] d0, d1;
    int r0, s0, bc;
    bit ok;
    hang = 1;
    req_data[7:0] = 8'($urandom);
    req_valid = 2'b01;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ready;
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({wr, reg_sel, rx_valid, busy, tx_error, req_ready, entrada, rx_data} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got %h expected 0", {wr, reg_sel, rx_valid, busy, tx_error, req_ready, entrada, rx_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    hang = 0;
    last_gnt = N - 1;
    r0 = ready_log.size(); s0 = sent_q.size();
    d0 = 8'($urandom); d1 = 8'($urandom);
    req_data = {d1, d0};
    req_valid = '1;
    wait_idle(1, bc, ok);
    req_valid = '0;
    last_gnt = 0;
    tests++;
    if (!ok || ready_at(r0) != 0 || sent_at(s0) !== d0) begin
      fails++;
      $display("FAIL reset_ptr: got idx %0d byte %h expected idx 0 byte %h", ready_at(r0), sent_at(s0), d0);
    end
  endtask

  task automatic test_idle();
    int bad, w0;
    bad = 0;
    w0 = wlog.size();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr || busy || (req_ready != '0)) bad++;
    end
    tests++;
    if (bad != 0 || wlog.size() != w0) begin
      fails++;
      $display("FAIL idle_quiet: got %0d active cycles %0d writes expected 0", bad, wlog.size() - w0);
    end
  endtask

  task automatic test_protocol();
    tests++;
    if (wr_run_max > 2 || wr_run_max < 1) begin
      fails++;
      $display("FAIL wr_run: got max %0d expected 1..2", wr_run_max);
    end
    tests++;
    if (onehot_err != 0) begin
      fails++;
      $display("FAIL ready_onehot: got %0d multi-grant cycles expected 0", onehot_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_tx(8'hA5, 20, 0);
    test_single_tx(8'($urandom), $urandom_range(1, 30), 1);
    test_single_tx(8'($urandom), $urandom_range(1, 30), 0);
    test_rr_random();
    test_back_to_back();
    test_rx_priority(8'h3C, 8'($urandom));
    test_rx_priority(8'($urandom), 8'($urandom));
    test_timeout();
    test_reset_mid_wait();
    test_idle();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
